pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage pipeline. Each cycle it drives the PC load enable and the clear/load-enable pair of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB). It resolves the following into one consistent freeze/bubble pattern:
- load-use hazards;
- taken-branch redirects;
- multi-cycle multiply/divide occupancy of EX;
- data-memory wait states;
- halt.

---
 rtl/pipe_hazard_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush sequencer for a five-stage pipeline.
// Merges load-use, taken-branch, mul/div occupancy, memory wait states and
// halt into one freeze/bubble pattern on the PC and the four pipeline
// registers. All control outputs are combinational from the current state and
// inputs. State, md_cnt, md_done and stall_cnt are registered.
//
// Handshake note: the pipeline registers obey "_zero beats _en": a register
// whose _zero is high loads a bubble regardless of its _en. The memory side
// is a level handshake: mem_req marks an access in MEM, and mem_ready high
// in the same cycle means it completes and MEM may advance.
module pipe_hazard_ctrl #(
  parameter int MD_CYCLES = 32,
  parameter int CNT_BITS  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          id_rs,
  input  logic [4:0]          id_rt,
  input  logic                id_use_rs,
  input  logic                id_use_rt,
  input  logic                ex_ld,
  input  logic [4:0]          ex_rd,
  input  logic                ex_branch_taken,
  input  logic                ex_md_start,
  input  logic                mem_req,
  input  logic                mem_ready,
  input  logic                halt,
  output logic                pc_en,
  output logic                ifid_en,
  output logic                idex_en,
  output logic                exmem_en,
  output logic                memwb_en,
  output logic                ifid_zero,
  output logic                idex_zero,
  output logic                exmem_zero,
  output logic                memwb_zero,
  output logic                md_busy,
  output logic                halted,
  output logic [CNT_BITS-1:0] stall_cnt
);

  localparam int MDW = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MD_WAIT  = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALTED   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [MDW-1:0]        md_cnt_q, md_cnt_d;
  logic                  md_done_q, md_done_d;
  logic [CNT_BITS-1:0]   stall_cnt_q, stall_cnt_d;

  logic lu;
  logic mw;

  // Hazard detection: load result needed by ID, and memory not yet done.
  assign lu = ex_ld && (ex_rd != 5'd0) &&
              ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
  assign mw = mem_req && !mem_ready;

  // Output pattern and next-state selection for the current state.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_zero  = 1'b0;
    idex_zero  = 1'b0;
    exmem_zero = 1'b0;
    memwb_zero = 1'b0;
    state_d    = state_q;
    md_cnt_d   = md_cnt_q;

    if (rst) begin
      // Reset: freeze everything and flush every register.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      ifid_zero  = 1'b1;
      idex_zero  = 1'b1;
      exmem_zero = 1'b1;
      memwb_zero = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (halt) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            state_d  = ST_HALTED;
          end else if (mw) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_zero = 1'b1;
            state_d    = ST_MEM_WAIT;
          end else if (ex_md_start && !md_done_q) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_zero = 1'b1;
            md_cnt_d   = MDW'(MD_CYCLES - 2);
            state_d    = ST_MD_WAIT;
          end else if (ex_branch_taken) begin
            // Wrong-path instructions in IF and ID are squashed; PC takes target.
            ifid_zero = 1'b1;
            idex_zero = 1'b1;
          end else if (lu) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_zero = 1'b1;
          end
        end
        ST_MD_WAIT: begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_en    = 1'b0;
          exmem_zero = 1'b1;
          if (mw) begin
            exmem_en   = 1'b0;
            memwb_zero = 1'b1;
          end
          if (md_cnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            md_cnt_d = md_cnt_q - MDW'(1);
          end
        end
        ST_MEM_WAIT: begin
          // Other hazards are ignored on the release cycle; EX is re-examined next.
          if (mw) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_zero = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_HALTED: begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          memwb_en = 1'b0;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // md_done tracking and saturating stall counter next values.
  always_comb begin
    md_done_d = md_done_q;
    if (idex_en || idex_zero) begin
      md_done_d = 1'b0;
    end
    if ((state_q == ST_MD_WAIT) && (md_cnt_q == '0)) begin
      md_done_d = 1'b1;
    end

    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (state_q != ST_HALTED) && (stall_cnt_q != {CNT_BITS{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_BITS'(1);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      md_cnt_q    <= '0;
      md_done_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      md_done_q   <= md_done_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign md_busy   = !rst && (state_q == ST_MD_WAIT);
  assign halted    = !rst && (state_q == ST_HALTED);
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: table of per-cycle vectors plus hand-written
// sequences for asynchronous reset and stall counter saturation.
module tb_pipe_hazard_ctrl;

  localparam int MDC = 4;
  localparam int CB  = 4;

  // Control pattern order: {pc, ifid, idex, exmem, memwb, zifid, zidex, zexmem, zmemwb}
  localparam logic [8:0] P_DEF  = 9'b11111_0000;
  localparam logic [8:0] P_LU   = 9'b00111_0100;
  localparam logic [8:0] P_BR   = 9'b11111_1100;
  localparam logic [8:0] P_MW   = 9'b00001_0001;
  localparam logic [8:0] P_MD   = 9'b00011_0010;
  localparam logic [8:0] P_MDMW = 9'b00001_0011;
  localparam logic [8:0] P_HALT = 9'b00000_0000;
  localparam logic [8:0] P_RST  = 9'b00000_1111;

  logic clk, rst;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic id_use_rs, id_use_rt, ex_ld, ex_branch_taken, ex_md_start;
  logic mem_req, mem_ready, halt;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_zero, idex_zero, exmem_zero, memwb_zero;
  logic md_busy, halted;
  logic [CB-1:0] stall_cnt;
  logic [8:0] ctl;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt, ld;
    logic [4:0] rd;
    logic       br, md, mreq, mrdy, hlt;
    logic [8:0] ctl;
    logic       busy, hltd;
    logic [3:0] scnt;
  } vec_t;

  vec_t tv[$];

  pipe_hazard_ctrl #(.MD_CYCLES(MDC), .CNT_BITS(CB)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_ld(ex_ld), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .ex_md_start(ex_md_start), .mem_req(mem_req), .mem_ready(mem_ready), .halt(halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_zero(ifid_zero), .idex_zero(idex_zero),
    .exmem_zero(exmem_zero), .memwb_zero(memwb_zero),
    .md_busy(md_busy), .halted(halted), .stall_cnt(stall_cnt)
  );

  assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_zero, idex_zero, exmem_zero, memwb_zero};

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_ld = 1'b0; ex_rd = 5'd0; ex_branch_taken = 1'b0; ex_md_start = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; halt = 1'b0;
  endtask

  task automatic add(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                     input logic urt, input logic ld, input logic [4:0] rd,
                     input logic br, input logic md, input logic mreq, input logic mrdy,
                     input logic hlt, input logic [8:0] c, input logic busy,
                     input logic hltd, input logic [3:0] scnt);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.ld = ld; v.rd = rd;
    v.br = br; v.md = md; v.mreq = mreq; v.mrdy = mrdy; v.hlt = hlt;
    v.ctl = c; v.busy = busy; v.hltd = hltd; v.scnt = scnt;
    tv.push_back(v);
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();

    //   rs  rt urs urt ld rd  br md mq mr h   ctl    busy hl scnt
    add(0,  0, 0,  0,  0, 0,  0, 0, 0, 0, 0, P_DEF,  0,   0, 0);  // idle
    add(5,  0, 1,  0,  1, 5,  0, 0, 0, 0, 0, P_LU,   0,   0, 0);  // load-use rs
    add(0,  0, 0,  0,  0, 0,  0, 0, 0, 0, 0, P_DEF,  0,   0, 1);  // one stall only
    add(0,  0, 1,  0,  1, 0,  0, 0, 0, 0, 0, P_DEF,  0,   0, 1);  // rd=0 no stall
    add(7,  7, 0,  1,  1, 7,  0, 0, 0, 0, 0, P_LU,   0,   0, 1);  // load-use rt
    add(7,  7, 0,  0,  1, 7,  0, 0, 0, 0, 0, P_DEF,  0,   0, 2);  // not used
    add(5,  0, 1,  0,  1, 5,  1, 0, 0, 0, 0, P_BR,   0,   0, 2);  // branch beats lu
    add(0,  0, 0,  0,  0, 0,  0, 0, 0, 0, 0, P_DEF,  0,   0, 2);  // no freeze
    add(0,  0, 0,  0,  0, 0,  0, 1, 0, 0, 0, P_MD,   0,   0, 2);  // md cycle 1
    add(0,  0, 0,  0,  0, 0,  0, 1, 0, 0, 0, P_MD,   1,   0, 3);  // md cycle 2
    add(0,  0, 0,  0,  0, 0,  0, 1, 0, 0, 0, P_MD,   1,   0, 4);  // md cycle 3
    add(0,  0, 0,  0,  0, 0,  0, 1, 0, 0, 0, P_MD,   1,   0, 5);  // md cycle 4
    add(0,  0, 0,  0,  0, 0,  0, 1, 0, 0, 0, P_DEF,  0,   0, 6);  // md cycle 5: advance
    add(0,  0, 0,  0,  0, 0,  0, 1, 0, 0, 0, P_MD,   0,   0, 6);  // new md
    add(0,  0, 0,  0,  0, 0,  0, 1, 1, 0, 0, P_MDMW, 1,   0, 7);  // md wait + mem wait
    add(0,  0, 0,  0,  0, 0,  0, 1, 0, 0, 0, P_MD,   1,   0, 8);
    add(0,  0, 0,  0,  0, 0,  0, 1, 0, 0, 0, P_MD,   1,   0, 9);
    add(0,  0, 0,  0,  0, 0,  0, 1, 0, 0, 0, P_DEF,  0,   0, 10); // release at 5
    add(0,  0, 0,  0,  0, 0,  0, 0, 0, 0, 0, P_DEF,  0,   0, 10);
    add(0,  0, 0,  0,  0, 0,  0, 0, 1, 0, 0, P_MW,   0,   0, 10); // mem wait 1
    add(0,  0, 0,  0,  0, 0,  0, 0, 1, 0, 0, P_MW,   0,   0, 11); // mem wait 2
    add(0,  0, 0,  0,  0, 0,  0, 0, 1, 0, 0, P_MW,   0,   0, 12); // mem wait 3
    add(5,  0, 1,  0,  1, 5,  1, 0, 1, 1, 0, P_DEF,  0,   0, 13); // ready: others ignored
    add(0,  0, 0,  0,  0, 0,  0, 0, 0, 0, 0, P_DEF,  0,   0, 13);
    add(0,  0, 0,  0,  0, 0,  0, 0, 1, 1, 0, P_DEF,  0,   0, 13); // ready at once: no wait
    add(0,  0, 0,  0,  0, 0,  0, 0, 1, 0, 1, P_HALT, 0,   0, 13); // halt beats mw
    add(0,  0, 0,  0,  0, 0,  1, 0, 0, 0, 0, P_HALT, 0,   1, 14); // halted
    add(0,  0, 0,  0,  0, 0,  0, 1, 0, 0, 0, P_HALT, 0,   1, 14); // stays halted

    // Reset state while rst held across edges.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ctl", 32'(ctl), 32'(P_RST));
    chk("rst_busy", 32'(md_busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_scnt", 32'(stall_cnt), 32'd0);
    rst = 1'b0;

    // Table-driven per-cycle vectors.
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      id_rs = tv[i].rs; id_rt = tv[i].rt; id_use_rs = tv[i].urs; id_use_rt = tv[i].urt;
      ex_ld = tv[i].ld; ex_rd = tv[i].rd; ex_branch_taken = tv[i].br;
      ex_md_start = tv[i].md; mem_req = tv[i].mreq; mem_ready = tv[i].mrdy;
      halt = tv[i].hlt;
      #1;
      chk($sformatf("v%0d_ctl", i), 32'(ctl), 32'(tv[i].ctl));
      chk($sformatf("v%0d_busy", i), 32'(md_busy), 32'(tv[i].busy));
      chk($sformatf("v%0d_halted", i), 32'(halted), 32'(tv[i].hltd));
      chk($sformatf("v%0d_scnt", i), 32'(stall_cnt), 32'(tv[i].scnt));
    end

    // Asynchronous reset mid-cycle from HALTED.
    drive_idle();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_halt_ctl", 32'(ctl), 32'(P_RST));
    chk("arst_halt_halted", 32'(halted), 32'd0);
    chk("arst_halt_scnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    #3;
    rst = 1'b0;

    // Asynchronous reset mid-cycle from MD_WAIT.
    @(negedge clk);
    ex_md_start = 1'b1;
    #1;
    chk("md2_c1_ctl", 32'(ctl), 32'(P_MD));
    @(negedge clk);
    #1;
    chk("md2_c2_busy", 32'(md_busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_md_busy", 32'(md_busy), 32'd0);
    chk("arst_md_ctl", 32'(ctl), 32'(P_RST));
    drive_idle();
    @(negedge clk);
    #3;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_ctl", 32'(ctl), 32'(P_DEF));
    chk("post_rst_busy", 32'(md_busy), 32'd0);
    chk("post_rst_scnt", 32'(stall_cnt), 32'd0);

    // Stall counter saturation under a long memory wait.
    mem_req = 1'b1;
    mem_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
    end
    #1;
    chk("sat_ctl", 32'(ctl), 32'(P_MW));
    chk("sat_scnt", 32'(stall_cnt), 32'd15);
    @(negedge clk);
    #1;
    chk("sat_hold", 32'(stall_cnt), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
